// File: rtl/fmap_capture_mc.sv
// rtl/fmap_capture_mc.sv - multi-channel feature-map capture into display BRAM
// Quantises incoming columns into a two-entry ping-pong buffer and streams them out one byte per clock.
module fmap_capture_mc #(
    parameter int PIX_W     = 24,
    parameter int PIX_H     = 24,
    parameter int N_CH      = 4,
    parameter int DATA_W    = 24,
    parameter int BASE_ADDR = 0,
    parameter int CH_STRIDE = 576,
    parameter int ADDR_W    = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     valid_col,
    output logic                                     ready_col,
    input  logic [N_CH-1:0][PIX_H-1:0][DATA_W-1:0]   data_col,
    input  logic                                     quant_mode,
    input  logic [$clog2(DATA_W)-1:0]                quant_shift,
    input  logic                                     frame_abort,
    output logic [ADDR_W-1:0]                        bram_addr,
    output logic [7:0]                               bram_wdata,
    output logic                                     bram_we,
    output logic                                     busy,
    output logic                                     done
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CH_W  = (N_CH  > 1) ? $clog2(N_CH)  : 1;
    localparam int ROW_W = (PIX_H > 1) ? $clog2(PIX_H) : 1;
    localparam int COL_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIX_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIX_W - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         full_q, full_d;
    logic               wr_sel_q, wr_sel_d;
    logic               rd_sel_q, rd_sel_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               map_last_q, map_last_d;

    logic [1:0][N_CH-1:0][PIX_H-1:0][7:0] buf_q;
    logic [N_CH-1:0][PIX_H-1:0][7:0]      quant_col;
    logic                                 capture;
    logic                                 emit;
    logic                                 col_end;

    function automatic logic [7:0] quantise(input logic [DATA_W-1:0] v,
                                            input logic              mode,
                                            input logic [SH_W-1:0]   sh);
        logic [DATA_W-1:0] t;
        if (!mode) return v[DATA_W-1 -: 8];
        if (v[DATA_W-1]) return 8'd0;
        t = v >> sh;
        if (|t[DATA_W-1:8]) return 8'hFF;
        return t[7:0];
    endfunction

    always_comb begin
        quant_col = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int r = 0; r < PIX_H; r++) begin
                quant_col[c][r] = quantise(data_col[c][r], quant_mode, quant_shift);
            end
        end
    end

    assign capture = valid_col && ready_q;
    // The buffer under read stays full until its last byte is registered, so it doubles as the emit request.
    assign emit    = full_q[rd_sel_q];
    assign col_end = emit && (ch_q == CH_LAST) && (row_q == ROW_LAST);

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        ch_d       = ch_q;
        row_d      = row_q;
        col_d      = col_q;
        we_d       = emit;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = map_last_q;
        map_last_d = 1'b0;

        case (state_q)
            IDLE:    if (emit)  state_d = WRITE;
            WRITE:   if (!emit) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (emit) begin
            addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(ch_q) * ADDR_W'(CH_STRIDE)
                    + ADDR_W'(row_q) * ADDR_W'(PIX_W) + ADDR_W'(col_q);
            wdata_d = buf_q[rd_sel_q][ch_q][row_q];
            if (row_q == ROW_LAST) begin
                row_d = '0;
                ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
            end else begin
                row_d = row_q + ROW_W'(1);
            end
            if (col_end) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
                if (col_q == COL_LAST) begin
                    col_d      = '0;
                    map_last_d = 1'b1;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
        end

        if (capture) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end

        if (frame_abort) begin
            state_d    = IDLE;
            full_d     = '0;
            wr_sel_d   = 1'b0;
            rd_sel_d   = 1'b0;
            ch_d       = '0;
            row_d      = '0;
            col_d      = '0;
            we_d       = 1'b0;
            done_d     = 1'b0;
            map_last_d = 1'b0;
        end

        ready_d = ~(full_d[0] & full_d[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            ch_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            ready_q    <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            map_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            ch_q       <= ch_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            map_last_q <= map_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture && !frame_abort) buf_q[wr_sel_q] <= quant_col;
    end

    assign ready_col  = ready_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign done       = done_q;
    assign busy       = (|full_q) || (state_q == WRITE);

endmodule

// File: doc/fmap_capture_mc.md
Name: fmap_capture_mc

Overview:
Multi-channel feature-map capture stage between a CNN layer's column output and the shared display BRAM. Each accepted column holds N_CH×PIX_H values, quantised to 8-bit greyscale by a run-time mode. The block writes one byte per clock to a per-channel region of the BRAM. A two-entry ping-pong column buffer lets the CNN deliver the next column while the current one is being written out, so stalls happen only when both entries are occupied.

Parameters:
PIX_W, 24, map width (columns per map)
PIX_H, 24, map height (rows per column)
N_CH, 4, channels delivered in parallel per column
DATA_W, 24, width of each input value (signed two's complement)
BASE_ADDR, 0, byte address of channel 0, row 0, col 0
CH_STRIDE, 576, byte offset between channel regions (≥ PIX_W*PIX_H)
ADDR_W, 16, BRAM address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
valid_col  in  1  column available
ready_col  out  1  block can accept a column this cycle
data_col  in  [N_CH][PIX_H]×DATA_W  column values, channel-major
quant_mode  in  1  0 = take MS byte; 1 = ReLU + shift + saturate
quant_shift  in  $clog2(DATA_W)  right-shift amount for mode 1
frame_abort  in  1  synchronous drop of the partial map
bram_addr  out  ADDR_W  write address
bram_wdata  out  8  write byte
bram_we  out  1  write strobe
busy  out  1  a buffer is occupied or a write is in progress
done  out  1  1-cycle pulse after the last byte of the map is written

Behaviour:
- Reset (async): ready_col=1, bram_we=0, bram_addr=0, bram_wdata=0, done=0, busy=0. Both buffers empty; ch/row/col pointers=0. Asserting reset mid-map abandons the partial map; no done pulse.
- ready_col = (occupancy != 2). It is driven from registers only, with no combinational path from valid_col.
- Capture: on an edge where valid_col && ready_col, all N_CH×PIX_H values are quantised and stored in the free buffer (ping first after reset, then alternating). quant_mode and quant_shift are sampled on that edge.
- Mode 0: byte = value[DATA_W-1 -: 8].
- Mode 1: if value < 0, byte = 0. Otherwise t = value >>> quant_shift, byte = (t > 255) ? 255 : t[7:0].
- Writer FSM states: IDLE, WRITE.
  - IDLE → WRITE on the edge after a buffer becomes full. The first bram_we=1 is registered on the capture edge + 1.
  - WRITE emits one byte per edge in order ch 0..N_CH-1 (outer), row 0..PIX_H-1 (inner).
  - Address: bram_addr = BASE_ADDR + ch*CH_STRIDE + row*PIX_W + col, computed at ADDR_W bits and truncated.
  - Each column takes N_CH*PIX_H consecutive bram_we cycles.
- End of a column:
  - The buffer is released on the edge that registers its last byte.
  - If the other buffer is full, WRITE continues with it on the next edge with no gap. Otherwise the FSM returns to IDLE.
  - col increments; at col == PIX_W-1 it wraps to 0 and done pulses one cycle, coincident with the cycle after the final bram_we.
- Simultaneous capture and release on the same edge: occupancy is unchanged, and ready_col stays 1 if occupancy was 1.
- With occupancy 2, ready_col is 0. It rises in the cycle after release.
- frame_abort (synchronous, priority over capture and write):
  - Empties both buffers, clears all pointers and col, sets bram_we=0 on the next edge.
  - ready_col=1 next cycle; no done pulse.
  - A valid_col on the same edge is ignored.
- busy = (occupancy != 0) || (FSM == WRITE).
- Inputs are not checked for X. quant_shift ≥ DATA_W gives t = 0.

Test Plan:
- Single column, N_CH=2, PIX_H=3, PIX_W=2, mode 0, value=0x7F0000+r → bytes 0x7F written to addresses {0,2,4, CH_STRIDE+0, +2, +4} on 6 consecutive cycles. First bram_we registered on capture edge + 1.
- Mode 1, shift=8, values {-5, 0x00FF00, 0x012345, 0x000080} → bytes {0, 255, 255, 0}.
- Back-to-back: valid_col held high for 3 columns → ready_col drops after 2 captures and reasserts the cycle after column 0's last byte. bram_we stays continuously high across 3×N_CH×PIX_H cycles.
- Full map of PIX_W columns → exactly one done pulse, the cycle after the final write to address BASE_ADDR+(N_CH-1)*CH_STRIDE+(PIX_H-1)*PIX_W+PIX_W-1. col wraps so the next map starts at col 0.
- frame_abort mid-column (after 5 writes) → bram_we=0 next cycle, no done, ready_col=1. The next column writes to col 0.
- Async rst asserted mid-WRITE → all outputs at reset values immediately. A fresh map then completes correctly.
